// File: rtl/bidirectional_reg.sv
// Serial-in, parallel-out shift register.
// Direction is selectable each cycle; out is driven from flops.
module bidirectional_reg #(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           d,
  input  logic           en,
  input  logic           dir,
  output logic [MSB-1:0] out
);

  logic [MSB-1:0] nxt;

  generate
    if (MSB == 1) begin : g_one
      // a single flop sees d from either direction
      always_comb nxt = d;
    end else begin : g_wide
      always_comb begin
        nxt = out;
        unique case (1'b1)
          dir:  nxt = {d, out[MSB-1:1]};
          !dir: nxt = {out[MSB-2:0], d};
          default: nxt = out;
        endcase
      end
    end
  endgenerate

  // rstn is active-high despite its name
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)
      out <= '0;
    else if (en)
      out <= nxt;
  end

endmodule

// File: tb/tb_bidirectional_reg.sv
// Directed bench for bidirectional_reg.
// Expected values are hand-computed.
module tb_bidirectional_reg;

  logic       clk = 1'b0;
  logic       rstn;
  logic       d;
  logic       en;
  logic       dir;
  logic [3:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  bidirectional_reg #(.MSB(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .d    (d),
    .en   (en),
    .dir  (dir),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (out === exp) else begin
      n_bad++;
      $error("FAIL %s: out=%b expected=%b", tag, out, exp);
    end
  endtask

  task automatic step(input logic sd, input logic sdir,
                      input logic sen);
    @(negedge clk);
    d   = sd;
    dir = sdir;
    en  = sen;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    d    = 1'b0;
    en   = 1'b0;
    dir  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_init", 4'b0000);
    @(negedge clk);
    rstn = 1'b0;

    // load 1011, then reset mid-cycle
    step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    chk("preload", 4'b1011);
    #2;
    rstn = 1'b1;
    #1;
    chk("async_rst", 4'b0000);
    step(1, 0, 1);
    chk("rst_hold1", 4'b0000);
    step(1, 1, 1);
    chk("rst_hold2", 4'b0000);
    @(negedge clk);
    rstn = 1'b0;

    // left shift
    step(1, 0, 1); chk("left1", 4'b0001);
    step(1, 0, 1); chk("left2", 4'b0011);
    step(0, 0, 1); chk("left3", 4'b0110);
    step(1, 0, 1); chk("left4", 4'b1101);

    // right shift from zero
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_again", 4'b0000);
    rstn = 1'b0;
    step(1, 1, 1); chk("right1", 4'b1000);
    step(0, 1, 1); chk("right2", 4'b0100);
    step(1, 1, 1); chk("right3", 4'b1010);
    step(1, 1, 1); chk("right4", 4'b1101);

    // direction change
    step(0, 1, 1); chk("dirchg_r", 4'b0110);
    step(1, 0, 1); chk("dirchg_l", 4'b1101);

    // hold
    step(0, 1, 1); chk("hold_setup", 4'b0110);
    step(1, 0, 0); chk("hold1", 4'b0110);
    step(0, 1, 0); chk("hold2", 4'b0110);
    step(1, 1, 0); chk("hold3", 4'b0110);
    step(0, 0, 0); chk("hold4", 4'b0110);
    step(1, 1, 0); chk("hold5", 4'b0110);
    step(1, 0, 1); chk("hold_exit", 4'b1101);

    // flush with alternating data
    for (int i = 0; i < 7; i++) step(~i[0], 0, 1);
    chk("flush_left", 4'b0101);
    step(0, 1, 1); chk("flush_r1", 4'b0010);
    step(0, 1, 1); chk("flush_r2", 4'b0001);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    chk("flush_right", 4'b0000);

    // bit travels to far end after 4 shifts
    step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("far_end", 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
